// File: rtl/mul_pipe_pkg.sv
// Shared constants, stage record and the extended multiply used by the
// mul_pipe_hs pipelined multiplier.
package mul_pipe_pkg;

  localparam int DEF_A_W    = 16;
  localparam int DEF_B_W    = 16;
  localparam int DEF_STAGES = 3;
  localparam int DEF_P_W    = DEF_A_W + DEF_B_W;

  // Widest operand the shared multiply handles; A_W and B_W must not exceed it.
  localparam int MUL_MAX_W  = 32;

  typedef struct packed {
    logic               vld;
    logic [DEF_P_W-1:0] prod;
  } mul_stage_t;

  // Operands arrive left-aligned in MUL_MAX_W bits, so one signed/unsigned
  // extension serves any width; the product's top A_W+B_W bits are exact.
  function automatic logic [2*MUL_MAX_W-1:0] ext_mul(
    input logic [MUL_MAX_W-1:0] a,
    input logic [MUL_MAX_W-1:0] b,
    input logic                 sgn
  );
    logic [2*MUL_MAX_W-1:0] a_x;
    logic [2*MUL_MAX_W-1:0] b_x;
    a_x = {{MUL_MAX_W{sgn & a[MUL_MAX_W-1]}}, a};
    b_x = {{MUL_MAX_W{sgn & b[MUL_MAX_W-1]}}, b};
    return a_x * b_x;
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One enable-gated {valid, data} pipeline register with synchronous reset.
module mul_pipe_stage
  import mul_pipe_pkg::*;
#(
  parameter int W = DEF_P_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic         r_vld;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_en) begin
      r_vld  <= i_vld;
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake.
// Latency from accept to out_valid is STAGES+2 cycles; any stall freezes the whole pipe.
module mul_pipe_hs
  import mul_pipe_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] mul
);

  localparam int P_W = A_W + B_W;

  logic                        r_in_vld;
  logic [A_W-1:0]              r_a;
  logic [B_W-1:0]              r_b;
  logic                        r_sgn;
  logic                        r_out_vld;
  logic [P_W-1:0]              r_mul;

  logic                        w_adv;
  logic [2*MUL_MAX_W-1:0]      w_full;
  logic [P_W-1:0]              w_prod;
  logic [STAGES:0]             w_vld;
  logic [STAGES:0][P_W-1:0]    w_data;

  // The only place a stall can originate is a held, unconsumed output.
  assign w_adv    = ~r_out_vld | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_vld <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sgn    <= 1'b0;
    end else if (w_adv) begin
      r_in_vld <= in_valid;
      r_a      <= a;
      r_b      <= b;
      r_sgn    <= sgn;
    end
  end

  assign w_full = ext_mul(MUL_MAX_W'(r_a) << (MUL_MAX_W - A_W),
                          MUL_MAX_W'(r_b) << (MUL_MAX_W - B_W),
                          r_sgn);
  assign w_prod = P_W'(w_full >> (2*MUL_MAX_W - P_W));

  assign w_vld[0]  = r_in_vld;
  assign w_data[0] = w_prod;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      mul_pipe_stage #(
        .W (P_W)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_adv),
        .i_vld  (w_vld[gi]),
        .i_data (w_data[gi]),
        .o_vld  (w_vld[gi+1]),
        .o_data (w_data[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_mul     <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_vld[STAGES];
      r_mul     <= w_data[STAGES];
    end
  end

  assign out_valid = r_out_vld;
  assign mul       = r_mul;

endmodule
